// File: rtl/bus_arbiter_if.sv
// Bundle of the fetch port, data port, cache array port, UART and keyboard
// signals shared between the arbiter (slave) and the CPU/memory side (master).
interface bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_valid;
  logic        d_rd;
  logic        d_wr;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_valid;
  logic        bus_err;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        uart_wr_n;
  logic [31:0] uart_wdata;
  logic [7:0]  key_data;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, key_data,
    output if_data, if_valid, d_rdata, d_valid, bus_err,
           mem_addr, mem_we, mem_wdata, uart_wr_n, uart_wdata
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, key_data,
    input  if_data, if_valid, d_rdata, d_valid, bus_err,
           mem_addr, mem_we, mem_wdata, uart_wr_n, uart_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a shared synchronous cache array, with
// memory-mapped UART transmit and keyboard registers; round-robin on contention.
module bus_arbiter #(
  parameter logic [63:0] ROM_BASE = 64'h0000,
  parameter logic [63:0] ROM_SIZE = 64'h1000,
  parameter logic [63:0] RAM_BASE = 64'h1000,
  parameter logic [63:0] RAM_SIZE = 64'h1000,
  parameter logic [63:0] ART_BASE = 64'hFFFF,
  parameter logic [63:0] KEY_BASE = 64'hFFFE
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, RD_DONE, WR, RESP} state_t;

  state_t      r_state, w_state_next;
  logic        r_is_fetch, w_is_fetch_next;
  logic        r_is_write, w_is_write_next;
  logic        r_last_fetch, w_last_fetch_next;
  logic [63:0] r_addr, w_addr_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic [31:0] r_if_data, w_if_data_next;
  logic [63:0] r_d_rdata, w_d_rdata_next;
  logic        r_if_valid, w_if_valid_next;
  logic        r_d_valid, w_d_valid_next;
  logic        r_bus_err, w_bus_err_next;
  logic [10:0] r_mem_addr, w_mem_addr_next;
  logic        r_mem_we, w_mem_we_next;
  logic [31:0] r_mem_wdata, w_mem_wdata_next;
  logic        r_uart_wr_n, w_uart_wr_n_next;
  logic [31:0] r_uart_wdata, w_uart_wdata_next;

  logic        w_d_req;
  logic        w_grant_fetch;
  logic [63:0] w_rom_off, w_ram_off;
  logic        w_in_rom, w_in_ram, w_in_uart, w_in_key, w_in_mem;
  logic [31:0] w_swap;
  logic        w_unused;

  // Offset compares keep the range test valid for any base, including zero.
  assign w_rom_off = r_addr - ROM_BASE;
  assign w_ram_off = r_addr - RAM_BASE;
  assign w_in_rom  = (w_rom_off < ROM_SIZE);
  assign w_in_ram  = (w_ram_off < RAM_SIZE);
  assign w_in_uart = (r_addr == ART_BASE);
  assign w_in_key  = (r_addr == KEY_BASE);
  assign w_in_mem  = w_in_rom | w_in_ram;

  assign w_d_req  = bus.d_rd | bus.d_wr;
  assign w_swap   = {bus.mem_rdata[7:0], bus.mem_rdata[15:8],
                     bus.mem_rdata[23:16], bus.mem_rdata[31:24]};
  assign w_unused = ^bus.d_wdata[63:32];

  // On contention the requester that did not win last time is granted.
  assign w_grant_fetch = bus.if_req & (~w_d_req | ~r_last_fetch);

  always_comb begin
    w_state_next      = r_state;
    w_is_fetch_next   = r_is_fetch;
    w_is_write_next   = r_is_write;
    w_last_fetch_next = r_last_fetch;
    w_addr_next       = r_addr;
    w_wdata_next      = r_wdata;
    w_if_data_next    = r_if_data;
    w_d_rdata_next    = r_d_rdata;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_uart_wdata_next = r_uart_wdata;
    w_if_valid_next   = 1'b0;
    w_d_valid_next    = 1'b0;
    w_bus_err_next    = 1'b0;
    w_mem_we_next     = 1'b0;
    w_uart_wr_n_next  = 1'b1;

    case (r_state)
      IDLE: begin
        if (bus.if_req || w_d_req) begin
          w_is_fetch_next   = w_grant_fetch;
          w_is_write_next   = ~w_grant_fetch & bus.d_wr;
          w_last_fetch_next = w_grant_fetch;
          w_addr_next       = w_grant_fetch ? {32'b0, bus.if_addr} : bus.d_addr;
          w_wdata_next      = bus.d_wdata[31:0];
          w_mem_addr_next   = w_grant_fetch ? bus.if_addr[12:2] : bus.d_addr[12:2];
          w_state_next      = ADDR;
        end
      end
      ADDR: begin
        if (r_is_write) begin
          w_state_next = WR;
          if (w_in_ram) begin
            w_mem_we_next    = 1'b1;
            w_mem_wdata_next = r_wdata;
          end
          if (w_in_uart) begin
            w_uart_wr_n_next  = 1'b0;
            w_uart_wdata_next = r_wdata;
          end
        end else begin
          w_state_next = RD_DONE;
        end
      end
      RD_DONE: begin
        w_state_next = RESP;
        if (r_is_fetch) begin
          w_if_valid_next = 1'b1;
          w_bus_err_next  = ~w_in_mem;
          w_if_data_next  = w_in_mem ? w_swap : 32'h0000_0013;
        end else begin
          w_d_valid_next = 1'b1;
          if (w_in_mem) begin
            w_d_rdata_next = {32'b0, bus.mem_rdata};
          end else if (w_in_key) begin
            w_d_rdata_next = {56'b0, bus.key_data};
          end else if (w_in_uart) begin
            w_d_rdata_next = 64'b0;
          end else begin
            w_d_rdata_next = 64'hDEADBEEF_DEADBEEF;
            w_bus_err_next = 1'b1;
          end
        end
      end
      WR: begin
        w_state_next   = RESP;
        w_d_valid_next = 1'b1;
        w_bus_err_next = ~(w_in_ram | w_in_uart);
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state      <= IDLE;
      r_is_fetch   <= 1'b0;
      r_is_write   <= 1'b0;
      r_last_fetch <= 1'b1;
      r_addr       <= 64'b0;
      r_wdata      <= 32'b0;
      r_if_data    <= 32'b0;
      r_d_rdata    <= 64'b0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_bus_err    <= 1'b0;
      r_mem_addr   <= 11'b0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= 32'b0;
      r_uart_wr_n  <= 1'b1;
      r_uart_wdata <= 32'b0;
    end else begin
      r_state      <= w_state_next;
      r_is_fetch   <= w_is_fetch_next;
      r_is_write   <= w_is_write_next;
      r_last_fetch <= w_last_fetch_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
      r_if_data    <= w_if_data_next;
      r_d_rdata    <= w_d_rdata_next;
      r_if_valid   <= w_if_valid_next;
      r_d_valid    <= w_d_valid_next;
      r_bus_err    <= w_bus_err_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_uart_wr_n  <= w_uart_wr_n_next;
      r_uart_wdata <= w_uart_wdata_next;
    end
  end

  assign bus.if_data    = r_if_data;
  assign bus.if_valid   = r_if_valid;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.d_valid    = r_d_valid;
  assign bus.bus_err    = r_bus_err;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.uart_wr_n  = r_uart_wr_n;
  assign bus.uart_wdata = r_uart_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed transactions push expected
// responses and strobes; a forked monitor pops and compares them.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if bus();

  bus_arbiter dut (
    .CLOCK_50 (clk),
    .KEY0     (rst_n),
    .bus      (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cache array model: registered read, preset words at index 0 and 1.
  logic [31:0] tmem  [0:2047];
  logic        wrote [0:2047] = '{default: 1'b0};

  function automatic logic [31:0] dflt(input logic [10:0] a);
    case (a)
      11'd0:   dflt = 32'hCAFEF00D;
      11'd1:   dflt = 32'h13000000;
      default: dflt = {21'b0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) begin
      tmem[bus.mem_addr]  <= bus.mem_wdata;
      wrote[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= wrote[bus.mem_addr] ? tmem[bus.mem_addr] : dflt(bus.mem_addr);
  end

  typedef struct {
    logic        is_fetch;
    logic [63:0] data;
    logic        err;
    logic [10:0] maddr;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        uart;
    logic [10:0] maddr;
    logic [31:0] data;
  } str_t;

  exp_t exp_q[$];
  str_t str_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    str_t s;
    forever begin
      @(posedge clk);
      #1;
      if (bus.if_valid || bus.d_valid) begin
        chk("single_valid", {63'b0, bus.if_valid & bus.d_valid}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {62'b0, bus.if_valid, bus.d_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_kind", {63'b0, bus.if_valid}, {63'b0, e.is_fetch});
          if (e.is_fetch) chk("if_data", {32'b0, bus.if_data}, e.data);
          else            chk("d_rdata", bus.d_rdata, e.data);
          chk("bus_err", {63'b0, bus.bus_err}, {63'b0, e.err});
          chk("mem_addr", {53'b0, bus.mem_addr}, {53'b0, e.maddr});
          chk("latency", 64'(cyc), 64'(e.cyc));
          $display("txn %s data=%h err=%0b cycle=%0d", e.is_fetch ? "fetch" : "data ",
                   e.is_fetch ? {32'b0, bus.if_data} : bus.d_rdata, bus.bus_err, cyc);
        end
      end
      if (bus.mem_we) begin
        if (str_q.size() == 0 || str_q[0].uart) begin
          chk("unexpected_mem_we", 64'd1, 64'd0);
        end else begin
          s = str_q.pop_front();
          chk("we_mem_addr", {53'b0, bus.mem_addr}, {53'b0, s.maddr});
          chk("mem_wdata", {32'b0, bus.mem_wdata}, {32'b0, s.data});
          $display("txn mem_we addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
        end
      end
      if (!bus.uart_wr_n) begin
        if (str_q.size() == 0 || !str_q[0].uart) begin
          chk("unexpected_uart_wr", 64'd1, 64'd0);
        end else begin
          s = str_q.pop_front();
          chk("uart_wdata", {32'b0, bus.uart_wdata}, {32'b0, s.data});
          $display("txn uart_wr data=%h", bus.uart_wdata);
        end
      end
    end
  endtask

  task automatic push_exp(input bit f, input logic [63:0] d, input bit er,
                          input logic [10:0] m, input int c);
    exp_t e;
    e.is_fetch = f; e.data = d; e.err = er; e.maddr = m; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_str(input bit u, input logic [10:0] m, input logic [31:0] d);
    str_t s;
    s.uart = u; s.maddr = m; s.data = d;
    str_q.push_back(s);
  endtask

  // Issues one transaction from an idle arbiter; response due 3 cycles later.
  task automatic do_txn(input bit f, input bit rd, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [63:0] ed, input bit ee,
                        input logic [10:0] em);
    bit done;
    push_exp(f, ed, ee, em, cyc + 3);
    if (f) begin
      bus.if_req = 1'b1; bus.if_addr = addr[31:0];
    end else begin
      bus.d_rd = rd; bus.d_wr = wr; bus.d_addr = addr; bus.d_wdata = wd;
    end
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(posedge clk);
      #1;
      if (f ? bus.if_valid : bus.d_valid) done = 1'b1;
    end
    bus.if_req = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    chk("txn_done", {63'b0, done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int nd;
    int nf;
    bit seen;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    bus.d_addr = 64'h0; bus.d_wdata = 64'h0; bus.key_data = 8'h61;
    fork
      monitor_loop();
    join_none

    // Both requesters held from reset onward.
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    bus.d_rd = 1'b1;   bus.d_addr = 64'hFFFE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid",   {63'b0, bus.if_valid}, 64'd0);
    chk("rst_d_valid",    {63'b0, bus.d_valid}, 64'd0);
    chk("rst_bus_err",    {63'b0, bus.bus_err}, 64'd0);
    chk("rst_mem_we",     {63'b0, bus.mem_we}, 64'd0);
    chk("rst_uart_wr_n",  {63'b0, bus.uart_wr_n}, 64'd1);
    chk("rst_mem_addr",   {53'b0, bus.mem_addr}, 64'd0);
    chk("rst_mem_wdata",  {32'b0, bus.mem_wdata}, 64'd0);
    chk("rst_uart_wdata", {32'b0, bus.uart_wdata}, 64'd0);
    chk("rst_if_data",    {32'b0, bus.if_data}, 64'd0);
    chk("rst_d_rdata",    bus.d_rdata, 64'd0);

    c = cyc;
    push_exp(1'b0, 64'h61, 1'b0, 11'h7FF, c + 3);
    push_exp(1'b1, 64'h13, 1'b0, 11'h001, c + 7);
    push_exp(1'b0, 64'h61, 1'b0, 11'h7FF, c + 11);
    push_exp(1'b1, 64'h13, 1'b0, 11'h001, c + 15);
    rst_n = 1'b1;
    nd = 0; nf = 0;
    for (int i = 0; i < 40 && nf < 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.d_valid) begin nd++; if (nd == 2) bus.d_rd = 1'b0; end
      if (bus.if_valid) begin nf++; if (nf == 2) bus.if_req = 1'b0; end
    end
    chk("alternation_count", 64'(nd * 16 + nf), 64'h22);
    @(posedge clk);
    #1;

    do_txn(1'b1, 1'b0, 1'b0, 64'h4,    64'h0, 64'h13, 1'b0, 11'h001);
    push_str(1'b0, 11'h402, 32'hAABBCCDD);
    do_txn(1'b0, 1'b0, 1'b1, 64'h1008, 64'h11223344_AABBCCDD, 64'h61, 1'b0, 11'h402);
    do_txn(1'b0, 1'b1, 1'b0, 64'h1008, 64'h0, 64'hAABBCCDD, 1'b0, 11'h402);
    push_str(1'b1, 11'h0, 32'h41);
    do_txn(1'b0, 1'b0, 1'b1, 64'hFFFF, 64'h41, 64'hAABBCCDD, 1'b0, 11'h7FF);
    do_txn(1'b0, 1'b0, 1'b1, 64'h0010, 64'h99, 64'hAABBCCDD, 1'b1, 11'h004);
    do_txn(1'b0, 1'b1, 1'b0, 64'h8000, 64'h0, 64'hDEADBEEF_DEADBEEF, 1'b1, 11'h000);
    do_txn(1'b0, 1'b1, 1'b0, 64'hFFFF, 64'h0, 64'h0, 1'b0, 11'h7FF);
    do_txn(1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h13, 1'b1, 11'h000);
    do_txn(1'b1, 1'b0, 1'b0, 64'h1008, 64'h0, 64'hDDCCBBAA, 1'b0, 11'h402);
    push_str(1'b0, 11'h403, 32'h12345678);
    do_txn(1'b0, 1'b1, 1'b1, 64'h100C, 64'h12345678, 64'h0, 1'b0, 11'h403);
    do_txn(1'b0, 1'b1, 1'b0, 64'h0000, 64'h0, 64'hCAFEF00D, 1'b0, 11'h000);
    do_txn(1'b1, 1'b0, 1'b0, 64'h100C, 64'h0, 64'h78563412, 1'b0, 11'h403);

    // Reset asserted while the RAM write strobe is high.
    push_str(1'b0, 11'h404, 32'h55667788);
    bus.d_wr = 1'b1; bus.d_addr = 64'h1010; bus.d_wdata = 64'h55667788;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_we) seen = 1'b1;
    end
    chk("midwr_we_seen", {63'b0, seen}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midwr_mem_we",    {63'b0, bus.mem_we}, 64'd0);
    chk("midwr_uart_wr_n", {63'b0, bus.uart_wr_n}, 64'd1);
    chk("midwr_mem_addr",  {53'b0, bus.mem_addr}, 64'd0);
    chk("midwr_d_rdata",   bus.d_rdata, 64'd0);
    bus.d_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    do_txn(1'b0, 1'b1, 1'b0, 64'h1008, 64'h0, 64'hAABBCCDD, 1'b0, 11'h402);

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("str_q_empty", 64'(str_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameters: ROM_BASE 64'h0000 (ROM base address); ROM_SIZE 64'h1000 (ROM size in bytes); RAM_BASE 64'h1000 (RAM base address); RAM_SIZE 64'h1000 (RAM size in bytes); ART_BASE 64'hFFFF (UART transmit address); KEY_BASE 64'hFFFE (keyboard data address).
REQ-002 SHALL have ports:
- CLOCK_50 in 1: single clock; all logic on its rising edge.
- KEY0 in 1: asynchronous, active-low reset.
- if_req in 1: instruction-fetch request.
- if_addr in 32: fetch byte address.
- if_data out 32: fetched instruction, byte-swapped.
- if_valid out 1: fetch complete, one-cycle pulse.
- d_rd in 1: data read request.
- d_wr in 1: data write request.
- d_addr in 64: data byte address.
- d_wdata in 64: write data.
- d_rdata out 64: read data.
- d_valid out 1: data transaction complete, one-cycle pulse.
- bus_err out 1: error flag, pulses with the valid of the failing transaction.
- mem_addr out 11: word index into the 2048x32 cache array.
- mem_we out 1: cache write enable.
- mem_wdata out 32: cache write data.
- mem_rdata in 32: cache synchronous read data, valid one cycle after mem_addr.
- uart_wr_n out 1: active-low UART write strobe.
- uart_wdata out 32: UART write data.
- key_data in 8: current keyboard ASCII code.

Function
REQ-003 Address decode SHALL be:
- ROM: ROM_BASE <= addr < ROM_BASE+ROM_SIZE.
- RAM: RAM_BASE <= addr < RAM_BASE+RAM_SIZE.
- UART: addr == ART_BASE.
- KEY: addr == KEY_BASE.
- Any other address is unmapped.
- mem_addr = addr[12:2].
REQ-004 FSM states SHALL be IDLE, ADDR, RD_DONE, WR, RESP.
REQ-005 In IDLE with any request pending, the arbiter SHALL grant one requester, latch its address, write data and type, drive mem_addr, and go to ADDR.
REQ-006 When fetch and data requests are both pending in IDLE, grant SHALL alternate: the requester not granted last wins. After reset, data wins first.
REQ-007 Requests are level-sensitive. A requester SHALL hold its request stable until its valid pulse. The request is deasserted by the requester in the cycle after valid.
REQ-008 If d_rd and d_wr are both high, the transaction SHALL be treated as a write.
REQ-009 Read path: ADDR -> RD_DONE. Data SHALL be captured in RD_DONE, then RESP. Latency: request accepted at edge N, valid high during cycle N+3 exactly.
REQ-010 Fetch data SHALL be if_data = {r[7:0], r[15:8], r[23:16], r[31:24]} where r = mem_rdata. A fetch from a non-ROM/RAM address SHALL return 32'h00000013 and pulse bus_err.
REQ-011 Data read results SHALL be:
- ROM/RAM: d_rdata = {32'b0, mem_rdata}.
- KEY: d_rdata = {56'b0, key_data}, sampled in RD_DONE.
- UART: d_rdata = 0.
- Unmapped: d_rdata = 64'hDEADBEEF_DEADBEEF, with bus_err.
REQ-012 Write path: ADDR -> WR -> RESP. In WR:
- RAM target: mem_we = 1 for exactly one cycle, mem_wdata = d_wdata[31:0].
- UART target: uart_wr_n = 0 for exactly one cycle, uart_wdata = d_wdata[31:0].
REQ-013 Writes to ROM, KEY or unmapped addresses SHALL NOT assert mem_we or uart_wr_n, and SHALL pulse bus_err with d_valid.
REQ-014 RESP SHALL assert exactly one of if_valid/d_valid for one cycle, then return to IDLE. One transaction per 4 cycles maximum; a new grant is possible in the cycle after RESP.
REQ-015 mem_we SHALL be 0 in every state except WR.
REQ-016 d_rdata and if_data SHALL hold their last value between transactions.

Reset
REQ-017 While KEY0 = 0, the block SHALL immediately (asynchronously) force:
- state = IDLE.
- if_valid, d_valid, bus_err, mem_we = 0.
- uart_wr_n = 1.
- mem_addr = 0, mem_wdata = 0, uart_wdata = 0.
- if_data = 0, d_rdata = 0.
- last-grant = fetch, so data wins first.
REQ-018 Reset mid-transaction SHALL abandon the transaction: no valid, write strobe or UART strobe after KEY0 rises. The first request after reset is arbitrated fresh.

Verification
REQ-019 Fetch if_addr=0x4 with mem_rdata=0x13000000 -> if_valid exactly 3 cycles after acceptance, if_data=0x00000013, mem_addr=1.
REQ-020 Data write d_addr=0x1008, d_wdata=0xAABBCCDD -> one-cycle mem_we with mem_addr=0x402, mem_wdata=0xAABBCCDD; d_valid next cycle; bus_err=0.
REQ-021 Write to 0xFFFF with d_wdata=0x41 -> uart_wr_n low exactly one cycle, uart_wdata=0x41, mem_we never high. Write to 0x0010 (ROM) -> no mem_we, bus_err=1 with d_valid.
REQ-022 Read 0xFFFE with key_data=0x61 -> d_rdata=0x61. Read 0x8000 -> d_rdata=0xDEADBEEFDEADBEEF with bus_err=1.
REQ-023 if_req and d_rd held continuously from reset -> grants data, fetch, data, fetch, in strict alternation.
REQ-024 KEY0 low during WR of a RAM write -> mem_we drops immediately; no d_valid after release; next request completes normally.
